// File: rtl/rob_packet_receiver_pkg.sv
// Shared types for the ROB packet receiver: field types, receiver state
// enums, the assembled ROB entry write payload and the Decap* field
// extraction helpers for the DecoderToRob / RruToRob beat formats.
package rob_packet_receiver_pkg;

  localparam int unsigned ROB_INDEX_W = 7;
  localparam int unsigned PHY_REG_W   = 8;
  localparam int unsigned OP_ID_W     = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PC_W        = 64;

  typedef logic [ROB_INDEX_W-1:0] RobIndex_T;
  typedef logic [PHY_REG_W-1:0]   PhyRegisterId_T;
  typedef logic [OP_ID_W-1:0]     OperationId_T;
  typedef logic                   Boolean_T;
  typedef logic [DATA_W-1:0]      Data32_T;

  // Decoder channel: one state per expected beat, then wait for the join.
  typedef enum logic [2:0] {
    D_W1   = 3'd0,
    D_W2   = 3'd1,
    D_W3   = 3'd2,
    D_W4   = 3'd3,
    D_DONE = 3'd4
  } DecState_T;

  // RRU channel: two beats, then wait for the join.
  typedef enum logic [1:0] {
    R_W1   = 2'd0,
    R_W2   = 2'd1,
    R_DONE = 2'd2
  } RruState_T;

  typedef struct packed {
    RobIndex_T      robIndex;
    Boolean_T       isBranch;
    Boolean_T       isTaken;
    OperationId_T   opId;
    Data32_T        imm;
    logic [PC_W-1:0] pc;
    PhyRegisterId_T dstPhy;
    PhyRegisterId_T srcPhy1;
    PhyRegisterId_T srcPhy2;
    PhyRegisterId_T prevPhy;
  } RobEntryWrite_T;

  // Map a collector's beat index / done flag onto the named channel state.
  function automatic DecState_T DecStateOf(input logic [1:0] idx, input logic done);
    return done ? D_DONE : DecState_T'({1'b0, idx});
  endfunction

  function automatic RruState_T RruStateOf(input logic [1:0] idx, input logic done);
    return done ? R_DONE : RruState_T'(idx);
  endfunction

  // robIndex sits in bits [31:25] of both DecoderToRob1 and RruToRob1.
  function automatic RobIndex_T DecapRobIndex(input Data32_T w);
    return w[31:25];
  endfunction

  function automatic Boolean_T DecapIsBranch(input Data32_T w);
    return w[22];
  endfunction

  function automatic Boolean_T DecapIsTaken(input Data32_T w);
    return w[21];
  endfunction

  function automatic OperationId_T DecapOperationId(input Data32_T w);
    return w[7:0];
  endfunction

  function automatic logic [14:0] DecapDecReserved(input Data32_T w);
    return {w[24:23], w[20:8]};
  endfunction

  function automatic PhyRegisterId_T DecapDstPhy(input Data32_T w);
    return w[23:16];
  endfunction

  function automatic PhyRegisterId_T DecapSrcPhy1(input Data32_T w);
    return w[15:8];
  endfunction

  function automatic PhyRegisterId_T DecapSrcPhy2(input Data32_T w);
    return w[7:0];
  endfunction

  function automatic logic DecapRruReserved1(input Data32_T w);
    return w[24];
  endfunction

  function automatic PhyRegisterId_T DecapPrevPhy(input Data32_T w);
    return w[7:0];
  endfunction

  function automatic logic [23:0] DecapRruReserved2(input Data32_T w);
    return w[31:8];
  endfunction

endpackage

// File: rtl/rob_packet_receiver_beat.sv
// packet_beat_collector: counts accepted beats of one packet channel.
// Ports:
//   clk, resetN     clock and synchronous active-low reset
//   valid / ready   beat handshake; ready is low while done or in reset
//   beatIdx         index of the beat the next accept will capture
//   done            all BEATS beats received, waiting for release
//   releaseEn       return to the first beat (entry consumed or dropped)
module packet_beat_collector #(
  parameter int unsigned BEATS = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       valid,
  output logic       ready,
  output logic [1:0] beatIdx,
  output logic       done,
  input  logic       releaseEn
);

  localparam logic [1:0] LAST_IDX = 2'(BEATS - 1);

  logic [1:0] idxQ;
  logic [1:0] idxD;
  logic       doneQ;
  logic       doneD;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      idxQ  <= '0;
      doneQ <= 1'b0;
    end else begin
      idxQ  <= idxD;
      doneQ <= doneD;
    end
  end

  // Next state: advance per accepted beat, park in done until released.
  always_comb begin
    idxD  = idxQ;
    doneD = doneQ;
    if (releaseEn) begin
      idxD  = '0;
      doneD = 1'b0;
    end else if (valid && ready) begin
      if (idxQ == LAST_IDX) begin
        idxD  = '0;
        doneD = 1'b1;
      end else begin
        idxD = idxQ + 2'd1;
      end
    end
  end

  // Depends only on state and reset, never on valid.
  assign ready   = resetN && !doneQ;
  assign beatIdx = idxQ;
  assign done    = doneQ;

endmodule

// File: rtl/rob_packet_receiver.sv
// rob_packet_receiver: joins the 4-beat decoder packet and the 2-beat RRU
// packet for one instruction into a single ROB entry write.
// Ports:
//   clk, resetN                 clock, synchronous active-low reset
//   decValid/decReady/decData   DecoderToRob1..4 beat stream
//   rruValid/rruReady/rruData   RruToRob1..2 beat stream
//   entryValid/entryReady       assembled entry handshake to ROB storage
//   entry*                      assembled entry fields
//   errMismatch                 pulse: robIndex disagreement, both packets dropped
//   errReserved                 pulse: nonzero reserved bits in an accepted beat
//   errCount                    saturating count of error events
module rob_packet_receiver #(
  parameter bit          CHECK_RESERVED = 1'b1,
  parameter int unsigned ERR_COUNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   decValid,
  output logic                   decReady,
  input  logic [31:0]            decData,
  input  logic                   rruValid,
  output logic                   rruReady,
  input  logic [31:0]            rruData,
  output logic                   entryValid,
  input  logic                   entryReady,
  output logic [6:0]             entryRobIndex,
  output logic                   entryIsBranch,
  output logic                   entryIsTaken,
  output logic [7:0]             entryOpId,
  output logic [31:0]            entryImm,
  output logic [63:0]            entryPc,
  output logic [7:0]             entryDstPhy,
  output logic [7:0]             entrySrcPhy1,
  output logic [7:0]             entrySrcPhy2,
  output logic [7:0]             entryPrevPhy,
  output logic                   errMismatch,
  output logic                   errReserved,
  output logic [ERR_COUNT_W-1:0] errCount
);

  import rob_packet_receiver_pkg::*;

  localparam int unsigned          SUM_W   = ERR_COUNT_W + 2;
  localparam logic [ERR_COUNT_W-1:0] ERR_MAX = '1;

  logic [1:0]     decBeatIdx;
  logic [1:0]     rruBeatIdx;
  logic           decDone;
  logic           rruDone;
  logic           releaseEn;
  logic           decAccept;
  logic           rruAccept;
  DecState_T      decState;
  RruState_T      rruState;

  RobEntryWrite_T entryQ;
  RobIndex_T      rruRobIndexQ;
  logic           errReservedQ;
  logic           errReservedD;
  logic [ERR_COUNT_W-1:0] errCountQ;
  logic [ERR_COUNT_W-1:0] errCountD;
  logic [SUM_W-1:0]       errSum;
  logic           bothDone;
  logic           indexMatch;
  logic           decRsvHit;
  logic           rruRsvHit;

  packet_beat_collector #(.BEATS(4)) u_decCollector (
    .clk      (clk),
    .resetN   (resetN),
    .valid    (decValid),
    .ready    (decReady),
    .beatIdx  (decBeatIdx),
    .done     (decDone),
    .releaseEn(releaseEn)
  );

  packet_beat_collector #(.BEATS(2)) u_rruCollector (
    .clk      (clk),
    .resetN   (resetN),
    .valid    (rruValid),
    .ready    (rruReady),
    .beatIdx  (rruBeatIdx),
    .done     (rruDone),
    .releaseEn(releaseEn)
  );

  assign decState  = DecStateOf(decBeatIdx, decDone);
  assign rruState  = RruStateOf(rruBeatIdx, rruDone);
  assign decAccept = decValid && decReady;
  assign rruAccept = rruValid && rruReady;

  // Join: both packets complete; robIndex decides deliver or drop.
  assign bothDone    = decDone && rruDone;
  assign indexMatch  = (entryQ.robIndex == rruRobIndexQ);
  assign entryValid  = bothDone && indexMatch;
  assign errMismatch = bothDone && !indexMatch;
  assign releaseEn   = errMismatch || (entryValid && entryReady);

  // Reserved-field checks on the beat being accepted this cycle.
  always_comb begin
    decRsvHit = 1'b0;
    rruRsvHit = 1'b0;
    if (decAccept && (decState == D_W1)) begin
      decRsvHit = |DecapDecReserved(decData);
    end
    if (rruAccept && (rruState == R_W1)) begin
      rruRsvHit = DecapRruReserved1(rruData);
    end else if (rruAccept && (rruState == R_W2)) begin
      rruRsvHit = |DecapRruReserved2(rruData);
    end
    errReservedD = CHECK_RESERVED && (decRsvHit || rruRsvHit);
  end

  // Both error sources can land in one cycle, so the counter may add 2.
  always_comb begin
    errSum    = SUM_W'(errCountQ) + SUM_W'(errMismatch) + SUM_W'(errReservedQ);
    errCountD = (errSum > SUM_W'(ERR_MAX)) ? ERR_MAX : errSum[ERR_COUNT_W-1:0];
  end

  // Capture registers: each accepted beat fills its own fields.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      entryQ       <= '0;
      rruRobIndexQ <= '0;
      errReservedQ <= 1'b0;
      errCountQ    <= '0;
    end else begin
      if (decAccept) begin
        case (decState)
          D_W1: begin
            entryQ.robIndex <= DecapRobIndex(decData);
            entryQ.isBranch <= DecapIsBranch(decData);
            entryQ.isTaken  <= DecapIsTaken(decData);
            entryQ.opId     <= DecapOperationId(decData);
          end
          D_W2:    entryQ.imm        <= decData;
          D_W3:    entryQ.pc[63:32]  <= decData;
          D_W4:    entryQ.pc[31:0]   <= decData;
          default: ;
        endcase
      end
      if (rruAccept) begin
        case (rruState)
          R_W1: begin
            rruRobIndexQ   <= DecapRobIndex(rruData);
            entryQ.dstPhy  <= DecapDstPhy(rruData);
            entryQ.srcPhy1 <= DecapSrcPhy1(rruData);
            entryQ.srcPhy2 <= DecapSrcPhy2(rruData);
          end
          R_W2:    entryQ.prevPhy <= DecapPrevPhy(rruData);
          default: ;
        endcase
      end
      errReservedQ <= errReservedD;
      errCountQ    <= errCountD;
    end
  end

  assign errReserved   = errReservedQ;
  assign errCount      = errCountQ;
  assign entryRobIndex = entryQ.robIndex;
  assign entryIsBranch = entryQ.isBranch;
  assign entryIsTaken  = entryQ.isTaken;
  assign entryOpId     = entryQ.opId;
  assign entryImm      = entryQ.imm;
  assign entryPc       = entryQ.pc;
  assign entryDstPhy   = entryQ.dstPhy;
  assign entrySrcPhy1  = entryQ.srcPhy1;
  assign entrySrcPhy2  = entryQ.srcPhy2;
  assign entryPrevPhy  = entryQ.prevPhy;

endmodule

// File: doc/rob_packet_receiver.md
Name: rob_packet_receiver

Overview:
ROB-side receiving end of the decoder-to-ROB and RRU-to-ROB packet links. It accepts two independent streams of 32-bit words with valid/ready handshakes:
- DecoderToRob1..4: four beats per instruction.
- RruToRob1..2: two beats per instruction.

It decapsulates both streams, checks that their robIndex values agree, and presents one assembled ROB entry write to the ROB storage array. It also flags protocol errors.

Parameters:
CHECK_RESERVED, 1, when 1 a nonzero reserved field in any beat raises errReserved.
ERR_COUNT_W, 8, width of the saturating protocol-error counter.

Ports:
clk  input  1  system clock, all logic rising-edge.
resetN  input  1  synchronous active-low reset.
decValid  input  1  decoder beat valid.
decReady  output  1  receiver can accept a decoder beat.
decData  input  32  decoder beat, DecoderToRob1..4 in that order.
rruValid  input  1  RRU beat valid.
rruReady  output  1  receiver can accept an RRU beat.
rruData  input  32  RRU beat, RruToRob1..2 in that order.
entryValid  output  1  assembled entry available.
entryReady  input  1  ROB consumes the entry.
entryRobIndex  output  7  robIndex, bits [31:25] of word 1.
entryIsBranch  output  1  isBranchInstruction.
entryIsTaken  output  1  isBranchTaken.
entryOpId  output  8  operationId.
entryImm  output  32  lowerImmediate.
entryPc  output  64  {upperPC, lowerPC}.
entryDstPhy  output  8  dstPhyReg.
entrySrcPhy1  output  8  srcPhyReg1.
entrySrcPhy2  output  8  srcPhyReg2.
entryPrevPhy  output  8  prevMappedPhyReg.
errMismatch  output  1  one-cycle pulse: robIndex mismatch, both packets dropped.
errReserved  output  1  one-cycle pulse: reserved bits nonzero.
errCount  output  ERR_COUNT_W  saturating count of errMismatch and errReserved events.

Behaviour:
- Beat accepted when valid && ready.
- Decoder FSM states: D_W1 -> D_W2 -> D_W3 -> D_W4 -> D_DONE.
  - Each accepted beat advances one state and captures its fields.
  - decReady = (state != D_DONE).
- RRU FSM states: R_W1 -> R_W2 -> R_DONE.
  - rruReady = (state != R_DONE).
- The two channels run independently; either may finish first and waits in DONE.
- Join when both FSMs are in DONE:
  - robIndex equal: entryValid = 1, and the entry fields are driven from capture registers. entryValid first rises the cycle after the later final beat is accepted.
  - entryValid and all fields stay stable until entryReady. On the handshake cycle both FSMs go to W1 next cycle, and both readys are high that cycle.
  - robIndex differs: entryValid stays 0, errMismatch = 1 for that cycle, both FSMs go to W1 next cycle, captured data is discarded.
- Steady-state throughput: one entry per 5 cycles with ROB always ready.
- Reserved checks (CHECK_RESERVED = 1):
  - DecoderToRob1 bits [24:23] and [20:8].
  - RruToRob1 bit [24].
  - RruToRob2 bits [31:8].
  - A nonzero check raises errReserved the cycle after that beat is accepted. The beat is still accepted and its fields used.
- Simultaneous events:
  - errReserved and errMismatch in the same cycle increment errCount by 2.
  - errCount saturates at all-ones.
- Reset (resetN = 0 at clk edge, including mid-packet):
  - Both FSMs go to W1; entryValid, errMismatch, errReserved, errCount and all capture registers go to 0.
  - Partially received packets are discarded.
  - During reset, decReady = rruReady = 0.
- No combinational path from any valid input to any ready output.

Decomposition:
- Packet package holds the receiver state enums and a packed RobEntryWrite struct carrying all entry fields.
- Type package keeps RobIndex_T, PhyRegisterId_T, OperationId_T, Boolean_T and Data32_T.
- Field extraction uses the existing Decap* functions.
- One sub-module, packet_beat_collector:
  - Parameter BEATS; ports: valid/ready, 2-bit beat index, done, release.
  - Instanced with BEATS = 4 for the decoder channel and BEATS = 2 for the RRU channel.

Test Plan:
- Matched packet: dec 0x0A600013, 0x00000004, 0x00000000, 0x80000000; rru 0x0A210203, 0x00000011; entryReady = 1 -> entryValid one cycle after last beat with robIndex 5, branch 1, taken 1, op 0x13, imm 4, pc 0x0000000080000000, dst 0x21, src1 0x02, src2 0x03, prev 0x11.
- Backpressure: same packets with entryReady = 0 for 6 cycles -> entryValid and fields stable, decReady = rruReady = 0, no beats lost; entry consumed on the first ready cycle.
- Mismatch: dec robIndex 5, rru word1 0x0C210203 (robIndex 6) -> errMismatch pulse, no entryValid, errCount = 1, next matched pair received normally.
- Reserved violation: dec word1 0x0A600113 -> errReserved pulse, entry still delivered with op 0x13, errCount increments.
- Reset mid-packet: resetN low after dec beat 2 -> all outputs 0; a fresh full packet afterwards produces a correct entry.
- Saturation: 300 mismatches with ERR_COUNT_W = 8 -> errCount holds at 255.
